// File: rtl/grid_io_pkg.sv
// Shared constants for the multi-pad IO grid tile: channel field layout,
// isolated-pad values and the per-channel chain width helper.
package grid_io_pkg;

  localparam int DIR_BIT = 0;
  localparam int INV_BIT = 1;
  localparam int PAR_BIT = 2;

  localparam logic DIR_SAFE = 1'b1;
  localparam logic OUT_SAFE = 1'b0;

  // Chain flops per channel; the parity build adds one bit at each channel's MSB.
  function automatic int cfg_bits_per_chan(input int cfg_bits, input bit par_en);
    return cfg_bits + (par_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/grid_io_chan.sv
// One SoC pad channel: direction/polarity data mux with safe isolation values.
module grid_io_chan
  import grid_io_pkg::*;
(
  input  logic i_active,
  input  logic i_dir,
  input  logic i_inv,
  input  logic i_pad_in,
  input  logic i_outpad,
  output logic o_pad_out,
  output logic o_pad_dir,
  output logic o_inpad
);

  always_comb begin
    o_pad_out = OUT_SAFE;
    o_pad_dir = DIR_SAFE;
    o_inpad   = 1'b0;
    if (i_active) begin
      if (i_dir) begin
        o_pad_dir = 1'b1;
        o_inpad   = i_pad_in ^ i_inv;
      end else begin
        o_pad_dir = 1'b0;
        o_pad_out = i_outpad ^ i_inv;
      end
    end
  end

endmodule

// File: rtl/grid_io_multi.sv
// NUM_IO-pad perimeter IO tile with serial config chain, load counter and gated release.
// Optional per-channel even parity checking is built when GRID_IO_CFG_PARITY_EN is defined.
module grid_io_multi
  import grid_io_pkg::*;
#(
  parameter int NUM_IO   = 4,
  parameter int CFG_BITS = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              IO_ISOL_N,
  input  logic              ccff_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad_upper,
  output logic [NUM_IO-1:0] io_inpad_lower
);

`ifdef GRID_IO_CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int W         = cfg_bits_per_chan(CFG_BITS, PAR_EN);
  localparam int CHAIN_LEN = NUM_IO * W;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  logic [CHAIN_LEN-1:0] r_chain;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 r_cfg_done;
  logic                 r_active;
  logic                 w_restart;
  logic                 w_cfg_err;
  logic                 w_active;
  logic [NUM_IO-1:0]    w_inpad;

  // Any shift into a completed chain starts a fresh load.
  assign w_restart = ccff_en & r_cfg_done;

  always_comb begin
    w_count_nxt = r_count;
    if (w_restart)
      w_count_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (ccff_en && (r_count != CNT_FULL))
      w_count_nxt = r_count + 1'b1;
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_chain    <= '0;
      r_count    <= '0;
      r_cfg_done <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      if (ccff_en)
        r_chain <= {r_chain[CHAIN_LEN-2:0], ccff_head};
      r_count    <= w_count_nxt;
      r_cfg_done <= (w_count_nxt == CNT_FULL) & ~w_restart;
      r_active   <= r_cfg_done & IO_ISOL_N & ~w_cfg_err;
    end
  end

`ifdef GRID_IO_CFG_PARITY_EN
  logic [NUM_IO-1:0] w_par_odd;
  logic              r_cfg_err;

  for (genvar g = 0; g < NUM_IO; g++) begin : g_par
    assign w_par_odd[g] = ^r_chain[g*W +: W];
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset)
      r_cfg_err <= 1'b0;
    else
      r_cfg_err <= r_cfg_done & ~w_restart & (|w_par_odd);
  end

  assign w_cfg_err = r_cfg_err;
`else
  assign w_cfg_err = 1'b0;
`endif

  // Release waits on r_active; every isolation cause also cuts the path immediately.
  assign w_active = r_active & r_cfg_done & IO_ISOL_N & ~w_cfg_err & ~w_restart;

  for (genvar g = 0; g < NUM_IO; g++) begin : g_chan
    grid_io_chan u_chan (
      .i_active  (w_active),
      .i_dir     (r_chain[g*W + DIR_BIT]),
      .i_inv     (r_chain[g*W + INV_BIT]),
      .i_pad_in  (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[g]),
      .i_outpad  (io_outpad[g]),
      .o_pad_out (gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[g]),
      .o_pad_dir (gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[g]),
      .o_inpad   (w_inpad[g])
    );
  end

  assign ccff_tail      = r_chain[CHAIN_LEN-1];
  assign cfg_done       = r_cfg_done;
  assign cfg_err        = w_cfg_err;
  assign io_inpad_upper = w_inpad;
  assign io_inpad_lower = w_inpad;

endmodule

// File: tb/tb_grid_io_multi.sv
// Directed bench for grid_io_multi (NUM_IO=4); parity scenario runs when GRID_IO_CFG_PARITY_EN is defined.
module tb_grid_io_multi;

`ifdef GRID_IO_CFG_PARITY_EN
  localparam int WT = 3;
`else
  localparam int WT = 2;
`endif
  localparam int CL = 4 * WT;

  logic       prog_clk;
  logic       pReset;
  logic       IO_ISOL_N;
  logic       ccff_en;
  logic       ccff_head;
  logic       ccff_tail;
  logic       cfg_done;
  logic       cfg_err;
  logic [3:0] pad_in;
  logic [3:0] pad_out;
  logic [3:0] pad_dir;
  logic [3:0] io_outpad;
  logic [3:0] inpad_up;
  logic [3:0] inpad_lo;

  int total;
  int bad;

  grid_io_multi #(.NUM_IO(4), .CFG_BITS(2)) dut (
    .prog_clk                         (prog_clk),
    .pReset                           (pReset),
    .IO_ISOL_N                        (IO_ISOL_N),
    .ccff_en                          (ccff_en),
    .ccff_head                        (ccff_head),
    .ccff_tail                        (ccff_tail),
    .cfg_done                         (cfg_done),
    .cfg_err                          (cfg_err),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir),
    .io_outpad                        (io_outpad),
    .io_inpad_upper                   (inpad_up),
    .io_inpad_lower                   (inpad_lo)
  );

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  // Chain image for per-channel dir/inv with correct even parity where present.
  function automatic logic [CL-1:0] mk_chain(input logic [3:0] d, input logic [3:0] inv);
    logic [CL-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*WT]     = d[i];
      r[i*WT + 1] = inv[i];
`ifdef GRID_IO_CFG_PARITY_EN
      r[i*WT + 2] = d[i] ^ inv[i];
`endif
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    ccff_en   = 1'b1;
    ccff_head = b;
    tick();
    ccff_en   = 1'b0;
  endtask

  task automatic load(input logic [CL-1:0] v);
    for (int k = CL - 1; k >= 0; k--) shift_bit(v[k]);
  endtask

  task automatic do_reset();
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    pReset = 1'b1; IO_ISOL_N = 1'b1; pad_in = 4'hF; io_outpad = 4'hF;
    #3;
    total++; if (pad_dir !== 4'hF) begin bad++; $display("FAIL reset_dir got=%b exp=1111", pad_dir); end
    total++; if (pad_out !== 4'h0) begin bad++; $display("FAIL reset_out got=%b exp=0000", pad_out); end
    total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", cfg_done); end
    total++; if (ccff_tail !== 1'b0) begin bad++; $display("FAIL reset_tail got=%b exp=0", ccff_tail); end
    total++; if (inpad_up !== 4'h0 || inpad_lo !== 4'h0) begin bad++; $display("FAIL reset_inpad got=%b/%b exp=0000", inpad_up, inpad_lo); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    tick(); pReset = 1'b0; tick(); tick();
    total++; if (pad_dir !== 4'hF || pad_out !== 4'h0) begin bad++; $display("FAIL post_reset_iso dir=%b out=%b exp=1111/0000", pad_dir, pad_out); end
  endtask

  task automatic test_tail_latency();
    do_reset();
    shift_bit(1'b1);
    for (int k = 0; k < CL - 2; k++) shift_bit(1'b0);
    total++; if (ccff_tail !== 1'b0) begin bad++; $display("FAIL tail_early got=%b exp=0", ccff_tail); end
    shift_bit(1'b0);
    total++; if (ccff_tail !== 1'b1) begin bad++; $display("FAIL tail_latency got=%b exp=1", ccff_tail); end
  endtask

  task automatic test_load_decode();
    logic [CL-1:0] v;
    v = mk_chain(4'b1001, 4'b0110);
    do_reset();
    IO_ISOL_N = 1'b1; pad_in = 4'hF; io_outpad = 4'h0;
    for (int k = CL - 1; k >= 1; k--) shift_bit(v[k]);
    total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL done_early got=%b exp=0", cfg_done); end
    shift_bit(v[0]);
    total++; if (cfg_done !== 1'b1) begin bad++; $display("FAIL load_done got=%b exp=1", cfg_done); end
    total++; if (pad_dir !== 4'hF) begin bad++; $display("FAIL release_delay got=%b exp=1111", pad_dir); end
    total++; if (ccff_tail !== v[CL-1]) begin bad++; $display("FAIL load_tail got=%b exp=%b", ccff_tail, v[CL-1]); end
    tick();
    total++; if (pad_dir !== 4'b1001) begin bad++; $display("FAIL active_dir got=%b exp=1001", pad_dir); end
    total++; if (pad_out !== 4'b0110) begin bad++; $display("FAIL active_out got=%b exp=0110", pad_out); end
    total++; if (inpad_up !== 4'b1001 || inpad_lo !== 4'b1001) begin bad++; $display("FAIL active_inpad got=%b/%b exp=1001", inpad_up, inpad_lo); end
    pad_in = 4'b0110; #1;
    total++; if (inpad_up !== 4'b0000) begin bad++; $display("FAIL inpad_blocked got=%b exp=0000", inpad_up); end
    pad_in = 4'b0001; #1;
    total++; if (inpad_up !== 4'b0001 || inpad_lo !== 4'b0001) begin bad++; $display("FAIL inpad_pass got=%b/%b exp=0001", inpad_up, inpad_lo); end
  endtask

  task automatic test_output_inv();
    io_outpad = 4'hF; #1;
    total++; if (pad_out !== 4'b0000 || pad_dir !== 4'b1001) begin bad++; $display("FAIL out_inv_hi out=%b dir=%b exp=0000/1001", pad_out, pad_dir); end
    io_outpad = 4'b0010; #1;
    total++; if (pad_out !== 4'b0100) begin bad++; $display("FAIL out_inv_mix got=%b exp=0100", pad_out); end
  endtask

  task automatic test_pause_resume();
    logic [CL-1:0] v;
    v = mk_chain(4'b0101, 4'b0011);
    do_reset();
    pad_in = 4'hF; io_outpad = 4'hF;
    for (int k = CL - 1; k >= CL - 3; k--) shift_bit(v[k]);
    for (int k = 0; k < 5; k++) tick();
    total++; if (cfg_done !== 1'b0 || pad_dir !== 4'hF) begin bad++; $display("FAIL pause_hold done=%b dir=%b exp=0/1111", cfg_done, pad_dir); end
    for (int k = CL - 4; k >= 1; k--) shift_bit(v[k]);
    total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL pause_count got=%b exp=0", cfg_done); end
    shift_bit(v[0]);
    total++; if (cfg_done !== 1'b1) begin bad++; $display("FAIL pause_done got=%b exp=1", cfg_done); end
    tick();
    total++; if (pad_dir !== 4'b0101 || pad_out !== 4'b1000 || inpad_up !== 4'b0100) begin
      bad++; $display("FAIL pause_decode dir=%b out=%b in=%b exp=0101/1000/0100", pad_dir, pad_out, inpad_up); end
  endtask

  task automatic test_isolation_drop();
    IO_ISOL_N = 1'b0; #1;
    total++; if (pad_dir !== 4'hF || pad_out !== 4'h0 || inpad_up !== 4'h0 || inpad_lo !== 4'h0) begin
      bad++; $display("FAIL isol_immediate dir=%b out=%b in=%b/%b exp=1111/0000/0000", pad_dir, pad_out, inpad_up, inpad_lo); end
    tick();
    IO_ISOL_N = 1'b1; #1;
    total++; if (pad_dir !== 4'hF) begin bad++; $display("FAIL isol_rerelease got=%b exp=1111", pad_dir); end
    tick();
    total++; if (pad_dir !== 4'b0101) begin bad++; $display("FAIL isol_reactivate got=%b exp=0101", pad_dir); end
  endtask

  task automatic test_restart();
    logic [CL-1:0] v;
    v = mk_chain(4'b1001, 4'b0110);
    shift_bit(v[CL-1]);
    total++; if (cfg_done !== 1'b0 || pad_dir !== 4'hF || pad_out !== 4'h0) begin
      bad++; $display("FAIL restart_iso done=%b dir=%b out=%b exp=0/1111/0000", cfg_done, pad_dir, pad_out); end
    for (int k = CL - 2; k >= 1; k--) shift_bit(v[k]);
    total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL restart_count got=%b exp=0", cfg_done); end
    shift_bit(v[0]);
    tick();
    total++; if (cfg_done !== 1'b1 || pad_dir !== 4'b1001) begin bad++; $display("FAIL restart_reload done=%b dir=%b exp=1/1001", cfg_done, pad_dir); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    for (int k = 0; k < 5; k++) shift_bit(1'b1);
    pReset = 1'b1; #1;
    total++; if (ccff_tail !== 1'b0 || cfg_done !== 1'b0) begin bad++; $display("FAIL midreset tail=%b done=%b exp=0/0", ccff_tail, cfg_done); end
    tick(); pReset = 1'b0; tick();
    for (int k = 0; k < CL - 1; k++) shift_bit(1'b0);
    total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL midreset_count got=%b exp=0", cfg_done); end
    shift_bit(1'b0);
    total++; if (cfg_done !== 1'b1) begin bad++; $display("FAIL midreset_done got=%b exp=1", cfg_done); end
  endtask

  task automatic test_reset_wins();
    pReset = 1'b1; ccff_en = 1'b1; ccff_head = 1'b1;
    for (int k = 0; k < CL + 2; k++) tick();
    total++; if (ccff_tail !== 1'b0 || cfg_done !== 1'b0) begin bad++; $display("FAIL reset_wins tail=%b done=%b exp=0/0", ccff_tail, cfg_done); end
    ccff_en = 1'b0; pReset = 1'b0; tick();
  endtask

  task automatic test_parity();
    logic [CL-1:0] v;
    v = mk_chain(4'b1001, 4'b0110);
    do_reset();
    IO_ISOL_N = 1'b1; pad_in = 4'hF;
`ifdef GRID_IO_CFG_PARITY_EN
    begin
      logic [CL-1:0] vb;
      vb = v;
      vb[2*WT + 2] = ~vb[2*WT + 2];
      load(vb);
      total++; if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin bad++; $display("FAIL par_pre done=%b err=%b exp=1/0", cfg_done, cfg_err); end
      tick();
      total++; if (cfg_err !== 1'b1 || pad_dir !== 4'hF) begin bad++; $display("FAIL par_err err=%b dir=%b exp=1/1111", cfg_err, pad_dir); end
      tick();
      total++; if (cfg_err !== 1'b1 || pad_dir !== 4'hF || inpad_up !== 4'h0) begin
        bad++; $display("FAIL par_hold err=%b dir=%b in=%b exp=1/1111/0000", cfg_err, pad_dir, inpad_up); end
      shift_bit(v[CL-1]);
      total++; if (cfg_err !== 1'b0 || cfg_done !== 1'b0) begin bad++; $display("FAIL par_restart err=%b done=%b exp=0/0", cfg_err, cfg_done); end
      for (int k = CL - 2; k >= 0; k--) shift_bit(v[k]);
      tick();
      total++; if (cfg_err !== 1'b0 || pad_dir !== 4'b1001) begin bad++; $display("FAIL par_good err=%b dir=%b exp=0/1001", cfg_err, pad_dir); end
    end
`else
    load(~v);
    tick();
    total++; if (cfg_err !== 1'b0 || pad_dir !== 4'b0110) begin bad++; $display("FAIL no_par err=%b dir=%b exp=0/0110", cfg_err, pad_dir); end
`endif
  endtask

  initial begin
    total = 0; bad = 0;
    pReset = 1'b1; IO_ISOL_N = 1'b1; ccff_en = 1'b0; ccff_head = 1'b0;
    pad_in = 4'h0; io_outpad = 4'h0;
    test_reset();
    test_tail_latency();
    test_load_decode();
    test_output_inv();
    test_pause_resume();
    test_isolation_drop();
    test_restart();
    test_reset_mid_load();
    test_reset_wins();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
